vga_ddp: RTL and testbench



---
 rtl/vga_ddp.sv | 165 ++++++++++++++++
 tb/tb_vga_ddp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_ddp.sv
// vga_ddp: display data processor between the scan timing generator and the
// VGA connector. Tracks the active-pixel coordinate, issues frame-buffer read
// addresses (4x upscaled 200x150 image) and drives hs/vs/de plus 4-bit RGB,
// all delay-matched to a fixed 3-cycle latency.
// Optional build macro: VGA_DDP_BORDER_EN (white one-pixel border around the
// active area).
module vga_ddp #(
  parameter int H_ACT       = 800,
  parameter int V_ACT       = 600,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_W        = 200,
  parameter int ADDR_W      = 15
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              hen,
  input  logic              ven,
  input  logic              hs,
  input  logic              vs,
  output logic [ADDR_W-1:0] raddr,
  input  logic [11:0]       rdata,
  output logic              hs_o,
  output logic              vs_o,
  output logic              de_o,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  localparam logic [9:0] H_MAX = 10'(H_ACT - 1);
  localparam logic [9:0] V_MAX = 10'(V_ACT - 1);

  // Coordinate tracking state
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       synced_q, synced_d;
  logic       hen_q, ven_q;

  // Pipeline state
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              valid1_q, hs1_q, vs1_q, de1_q;
  logic              valid2_q, hs2_q, vs2_q, de2_q;
  logic              hs3_q, vs3_q, de3_q;
  logic [11:0]       rgb_q, rgb_d;

  logic act;
  logic line_end;
  logic frame_end;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col_idx;

  assign act       = hen & ven;
  assign line_end  = hen_q & ~hen & ven;
  assign frame_end = ven_q & ~ven;

  // Next coordinate: frame end wins over line end; both counters saturate
  always_comb begin
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    synced_d = synced_q;
    if (frame_end) begin
      hcnt_d   = '0;
      vcnt_d   = '0;
      synced_d = 1'b1;
    end else if (line_end) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_MAX) ? vcnt_q : vcnt_q + 10'd1;
    end else if (act && (hcnt_q != H_MAX)) begin
      hcnt_d = hcnt_q + 10'd1;
    end
  end

  // Frame-buffer address from the current (pre-increment) coordinate
  always_comb begin
    row_base = ADDR_W'(vcnt_q >> SCALE_SHIFT) * ADDR_W'(FB_W);
    col_idx  = ADDR_W'(hcnt_q >> SCALE_SHIFT);
    raddr_d  = row_base + col_idx;
  end

`ifdef VGA_DDP_BORDER_EN
  // Coordinates travel with the pixel so the border test sees stage-3 values
  logic [9:0] h1_q, v1_q, h2_q, v2_q;

  // Coordinate pipeline alongside valid
  always_ff @(posedge pclk) begin
    if (rst) begin
      h1_q <= '0;
      v1_q <= '0;
      h2_q <= '0;
      v2_q <= '0;
    end else begin
      h1_q <= hcnt_q;
      v1_q <= vcnt_q;
      h2_q <= h1_q;
      v2_q <= v1_q;
    end
  end

  // Stage-3 colour: frame-buffer data, white on the outer ring, black when invalid
  always_comb begin
    rgb_d = valid2_q ? rdata : 12'h000;
    if (valid2_q && ((h2_q == 10'd0) || (h2_q == H_MAX) ||
                     (v2_q == 10'd0) || (v2_q == V_MAX))) begin
      rgb_d = 12'hFFF;
    end
  end
`else
  // Stage-3 colour: frame-buffer data, black when not a valid synced pixel
  always_comb begin
    rgb_d = valid2_q ? rdata : 12'h000;
  end
`endif

  // Counter, edge-detect and 3-stage output pipeline registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      synced_q <= 1'b0;
      hen_q    <= 1'b0;
      ven_q    <= 1'b0;
      raddr_q  <= '0;
      valid1_q <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      de1_q    <= 1'b0;
      valid2_q <= 1'b0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      de2_q    <= 1'b0;
      hs3_q    <= 1'b0;
      vs3_q    <= 1'b0;
      de3_q    <= 1'b0;
      rgb_q    <= '0;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      synced_q <= synced_d;
      hen_q    <= hen;
      ven_q    <= ven;
      raddr_q  <= raddr_d;
      valid1_q <= act & synced_q;
      hs1_q    <= hs;
      vs1_q    <= vs;
      de1_q    <= act;
      valid2_q <= valid1_q;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      de2_q    <= de1_q;
      hs3_q    <= hs2_q;
      vs3_q    <= vs2_q;
      de3_q    <= de2_q;
      rgb_q    <= rgb_d;
    end
  end

  assign raddr = raddr_q;
  assign hs_o  = hs3_q;
  assign vs_o  = vs3_q;
  assign de_o  = de3_q;
  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_ddp.sv
// tb_vga_ddp: frame-level bench for vga_ddp. Drives compressed frames (short
// lines except where a test needs a full or over-long line), models the RAM,
// and scores every cycle through expectation queues plus a table of
// hand-computed spot values.
module tb_vga_ddp;

  logic        pclk = 1'b0;
  logic        rst, hen, ven, hs, vs;
  logic [14:0] raddr;
  logic [11:0] rdata;
  logic        hs_o, vs_o, de_o;
  logic [3:0]  red, green, blue;

  always #5 pclk = ~pclk;

  vga_ddp dut (
    .pclk(pclk), .rst(rst), .hen(hen), .ven(ven), .hs(hs), .vs(vs),
    .raddr(raddr), .rdata(rdata), .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o),
    .red(red), .green(green), .blue(blue)
  );

  // RAM model: returns either its own address or a constant, one cycle later
  logic        ram_mode = 1'b0;
  logic [11:0] ram_const = 12'h000;
  always @(posedge pclk) rdata <= ram_mode ? raddr[11:0] : ram_const;

  typedef struct {
    logic        hs, vs, de;
    logic [11:0] rgb;
    logic        chk_addr;
    logic [14:0] addr;
    int          frame, row, col;
  } exp_t;

  typedef struct {
    int          long_row;
    int          long_len;
    logic        addr_mode;
    logic [11:0] cval;
    int          rst_row;
  } frame_t;

  typedef struct {
    int          frame, row, col;
    logic [14:0] addr;
    logic [11:0] rgb;
  } spot_t;

  exp_t   aq[$];
  exp_t   oq[$];
  spot_t  spots[$];
  frame_t frames[5];

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cur_frame = 0;
  logic synced_m = 1'b0;
  logic addr_known = 1'b0;
  logic prev_ven = 1'b0;

  function automatic logic [11:0] bval(input logic [11:0] x);
`ifdef VGA_DDP_BORDER_EN
    return 12'hFFF;
`else
    return x;
`endif
  endfunction

  // One input sample: build its expectation, advance a cycle, score outputs
  task automatic step(input logic r_v, h_v, v_v, hs_v, vs_v, input int row, col);
    exp_t e;
    exp_t z;
    int rr, cc;
    logic [11:0] data;
    rst = r_v; hen = h_v; ven = v_v; hs = hs_v; vs = vs_v;
    e = '{default: 0};
    z = '{default: 0};
    if (r_v) begin
      aq.delete();
      oq.delete();
      z.chk_addr = 1'b1;
      aq.push_back(z);
      z.chk_addr = 1'b0;
      repeat (3) oq.push_back(z);
      synced_m   = 1'b0;
      addr_known = ~v_v;
      prev_ven   = 1'b0;
    end else begin
      rr = (row > 599) ? 599 : row;
      cc = (col > 799) ? 799 : col;
      e.hs = hs_v; e.vs = vs_v; e.de = h_v & v_v;
      e.frame = cur_frame; e.row = row; e.col = col;
      e.addr = 15'((rr / 4) * 200 + cc / 4);
      e.chk_addr = e.de & addr_known;
      data = ram_mode ? e.addr[11:0] : ram_const;
      e.rgb = (e.de && synced_m) ? data : 12'h000;
`ifdef VGA_DDP_BORDER_EN
      if (e.de && synced_m && (rr == 0 || rr == 599 || cc == 0 || cc == 799))
        e.rgb = 12'hFFF;
`endif
      if (prev_ven && !v_v) begin
        synced_m   = 1'b1;
        addr_known = 1'b1;
      end
      prev_ven = v_v;
      aq.push_back(e);
      oq.push_back(e);
    end
    @(negedge pclk);
    e = aq.pop_front();
    if (e.chk_addr) begin
      n_cmp++;
      if (raddr !== e.addr) begin
        n_fail++;
        $display("FAIL raddr f%0d r%0d c%0d got=%0d want=%0d", e.frame, e.row, e.col, raddr, e.addr);
      end
      foreach (spots[i])
        if (spots[i].frame == e.frame && spots[i].row == e.row && spots[i].col == e.col) begin
          n_cmp++;
          if (raddr !== spots[i].addr) begin
            n_fail++;
            $display("FAIL spot_raddr f%0d r%0d c%0d got=%0d want=%0d", e.frame, e.row, e.col, raddr, spots[i].addr);
          end
        end
    end
    if (oq.size() == 3) begin
      e = oq.pop_front();
      n_cmp++;
      if ({hs_o, vs_o, de_o} !== {e.hs, e.vs, e.de}) begin
        n_fail++;
        $display("FAIL sync f%0d r%0d c%0d got hs/vs/de=%b want=%b", e.frame, e.row, e.col, {hs_o, vs_o, de_o}, {e.hs, e.vs, e.de});
      end
      n_cmp++;
      if ({red, green, blue} !== e.rgb) begin
        n_fail++;
        $display("FAIL rgb f%0d r%0d c%0d got=%h want=%h", e.frame, e.row, e.col, {red, green, blue}, e.rgb);
      end
      if (e.de)
        foreach (spots[i])
          if (spots[i].frame == e.frame && spots[i].row == e.row && spots[i].col == e.col) begin
            n_cmp++;
            if ({red, green, blue} !== spots[i].rgb) begin
              n_fail++;
              $display("FAIL spot_rgb f%0d r%0d c%0d got=%h want=%h", e.frame, e.row, e.col, {red, green, blue}, spots[i].rgb);
            end
          end
    end
  endtask

  // Vertical blanking with a vs pulse; RAM contents switch while nothing is in flight
  task automatic vblank(input logic mode, input logic [11:0] cval);
    for (int g = 0; g < 20; g++) begin
      if (g == 5) begin
        ram_mode  = mode;
        ram_const = cval;
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, (g >= 8 && g < 11), 0, 0);
    end
  endtask

  task automatic drive_frame(input frame_t f);
    int len;
    vblank(f.addr_mode, f.cval);
    for (int r = 0; r < 600; r++) begin
      len = (r == 0 || r == 599) ? 800 : ((r == f.long_row) ? f.long_len : 8);
      for (int c = 0; c < len; c++) begin
        if (r == f.rst_row && c == 4) begin
          step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, r, c);
          step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, r, c);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, r, c);
      end
      for (int g = 0; g < 4; g++)
        step(1'b0, 1'b0, 1'b1, (g == 1), 1'b0, r, 0);
    end
  endtask

  initial begin
    int f0;
    // frame records: {long_row, long_len, addr_mode, const, rst_row}
    frames[0] = '{-1,   0, 1'b0, 12'hABC, -1};  // unsynced first frame
    frames[1] = '{300, 810, 1'b1, 12'h000, -1}; // saturating line
    frames[2] = '{-1,   0, 1'b1, 12'h000, 300}; // reset mid-frame
    frames[3] = '{-1,   0, 1'b1, 12'h000, -1};  // recovered after frame end
    frames[4] = '{20, 800, 1'b0, 12'h000, -1};  // black RAM, border check

    // spot values: {frame, row, col, raddr, rgb}
    spots.push_back('{0,   9,   5,   401, 12'h000});
    spots.push_back('{1,   9,   5,   401, 12'h191});
    spots.push_back('{1, 300, 400, 15100, 12'hAFC});
    spots.push_back('{1, 300, 805, 15199, bval(12'hB5F)});
    spots.push_back('{1, 599, 799, 29999, bval(12'h52F)});
    spots.push_back('{2,   0,   0,     0, bval(12'h000)});
    spots.push_back('{3,   9,   5,   401, 12'h191});
    spots.push_back('{4,   0,  10,     2, bval(12'h000)});
    spots.push_back('{4, 599,  10, 29802, bval(12'h000)});
    spots.push_back('{4,  20,   0,  1000, bval(12'h000)});
    spots.push_back('{4,  20, 799,  1199, bval(12'h000)});
    spots.push_back('{4, 300, 400, 15100, 12'h000});

    // Reset state: every output must read 0 after the reset edge
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    for (int f = 0; f < 5; f++) begin
      cur_frame = f;
      f0 = n_fail;
      drive_frame(frames[f]);
      $display("frame %0d done: compared=%0d mismatched=%0d", f, n_cmp, n_fail - f0);
    end

    // Trailing frame end and pipeline drain
    cur_frame = 5;
    vblank(1'b0, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
